// File: rtl/sp_ram_be.sv
// -----------------------------------------------------------------------------
// sp_ram_be
//   Single-port RAM with per-byte write enables, a configurable read latency
//   (1 or 2 cycles), a selectable read-during-write behaviour and an optional
//   post-reset clear sequence that zeroes every word, one word per cycle.
//
// Parameters
//   ADDR_WIDTH      word address width
//   DATA_WIDTH      word width, a multiple of 8
//   DEPTH           number of words, 2 .. 2**ADDR_WIDTH
//   RD_LATENCY      cycles from accepted access to o_rvalid (1 or 2)
//   RDW_MODE        write response: 0 new word, 1 old word, 2 no response
//   CLEAR_ON_RESET  1 = zero the array after reset (o_busy meanwhile)
//
// Ports
//   I_CLK       clock, rising edge
//   I_RST       asynchronous active-high reset
//   i_cs        access request
//   i_we        1 = write, 0 = read
//   i_be        byte write enables, bit k covers data[8k+7:8k]
//   i_addr      word address
//   i_din       write data
//   o_dout      read data, held between responses
//   o_rvalid    one-cycle strobe, o_dout updated
//   o_busy      clear in progress, requests are dropped
//   o_addr_err  one-cycle strobe, access to an address >= DEPTH
// -----------------------------------------------------------------------------
module sp_ram_be #(
   parameter int ADDR_WIDTH     = 11,
   parameter int DATA_WIDTH     = 32,
   parameter int DEPTH          = 1920,
   parameter int RD_LATENCY     = 1,
   parameter int RDW_MODE       = 0,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                    I_CLK,
   input  logic                    I_RST,
   input  logic                    i_cs,
   input  logic                    i_we,
   input  logic [DATA_WIDTH/8-1:0] i_be,
   input  logic [ADDR_WIDTH-1:0]   i_addr,
   input  logic [DATA_WIDTH-1:0]   i_din,
   output logic [DATA_WIDTH-1:0]   o_dout,
   output logic                    o_rvalid,
   output logic                    o_busy,
   output logic                    o_addr_err
);

   localparam int NB = DATA_WIDTH / 8;
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic {
      ST_CLEAR,
      ST_READY
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [IW-1:0]         r_clr_cnt;
   logic [IW-1:0]         w_clr_cnt_nxt;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   logic                  w_in_range;
   logic                  w_acc;
   logic                  w_clr_we;
   logic                  w_wr_en;
   logic [IW-1:0]         w_idx;
   logic [DATA_WIDTH-1:0] w_rd_word;
   logic [DATA_WIDTH-1:0] w_merged;
   logic                  w_resp_vld;
   logic [DATA_WIDTH-1:0] w_resp_data;

   logic                  r_s1_vld;
   logic [DATA_WIDTH-1:0] r_s1_data;
   logic                  r_err;

   // Extra leading zero so DEPTH == 2**ADDR_WIDTH still compares correctly.
   assign w_in_range = ({1'b0, i_addr} < (ADDR_WIDTH + 1)'(DEPTH));
   assign w_idx      = i_addr[IW-1:0];

   // The array has no reset, so writes are also held off while I_RST is high.
   assign w_acc      = i_cs && (r_state == ST_READY) && !I_RST;
   assign w_clr_we   = (r_state == ST_CLEAR) && !I_RST;
   assign w_wr_en    = w_acc && i_we && w_in_range;
   assign w_rd_word  = w_in_range ? r_mem[w_idx] : '0;

   always_comb begin
      w_merged = w_rd_word;
      for (int unsigned k = 0; k < NB; k++) begin
         if (i_be[k]) begin
            w_merged[8*k +: 8] = i_din[8*k +: 8];
         end
      end
   end

   // Response word for the accepted access; out-of-range words read as zero.
   always_comb begin
      w_resp_vld  = 1'b0;
      w_resp_data = '0;
      if (w_acc) begin
         if (!i_we) begin
            w_resp_vld  = 1'b1;
            w_resp_data = w_rd_word;
         end else if (RDW_MODE == 0) begin
            w_resp_vld  = 1'b1;
            w_resp_data = w_in_range ? w_merged : '0;
         end else if (RDW_MODE == 1) begin
            w_resp_vld  = 1'b1;
            w_resp_data = w_rd_word;
         end
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_clr_cnt_nxt = r_clr_cnt;
      case (r_state)
         ST_CLEAR: begin
            if (r_clr_cnt == IW'(DEPTH - 1)) begin
               w_state_nxt   = ST_READY;
               w_clr_cnt_nxt = '0;
            end else begin
               w_clr_cnt_nxt = r_clr_cnt + 1'b1;
            end
         end
         ST_READY: begin
            w_state_nxt = ST_READY;
         end
         default: begin
            w_state_nxt   = ST_READY;
            w_clr_cnt_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge I_CLK or posedge I_RST) begin
      if (I_RST) begin
         r_state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
         r_clr_cnt <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_clr_cnt <= w_clr_cnt_nxt;
      end
   end

   always_ff @(posedge I_CLK) begin
      if (w_clr_we) begin
         r_mem[r_clr_cnt] <= '0;
      end else if (w_wr_en) begin
         r_mem[w_idx] <= w_merged;
      end
   end

   // First response stage; reset also discards anything in flight.
   always_ff @(posedge I_CLK or posedge I_RST) begin
      if (I_RST) begin
         r_s1_vld  <= 1'b0;
         r_s1_data <= '0;
         r_err     <= 1'b0;
      end else begin
         r_s1_vld <= w_resp_vld;
         if (w_resp_vld) begin
            r_s1_data <= w_resp_data;
         end
         r_err <= w_acc && !w_in_range;
      end
   end

   generate
      if (RD_LATENCY == 2) begin : g_lat2
         logic                  r_s2_vld;
         logic [DATA_WIDTH-1:0] r_s2_data;

         always_ff @(posedge I_CLK or posedge I_RST) begin
            if (I_RST) begin
               r_s2_vld  <= 1'b0;
               r_s2_data <= '0;
            end else begin
               r_s2_vld <= r_s1_vld;
               if (r_s1_vld) begin
                  r_s2_data <= r_s1_data;
               end
            end
         end

         assign o_rvalid = r_s2_vld;
         assign o_dout   = r_s2_data;
      end else begin : g_lat1
         assign o_rvalid = r_s1_vld;
         assign o_dout   = r_s1_data;
      end
   endgenerate

   assign o_busy     = (r_state == ST_CLEAR);
   assign o_addr_err = r_err;

endmodule

// File: tb/tb_sp_ram_be.sv
// -----------------------------------------------------------------------------
// tb_sp_ram_be
//   Three sp_ram_be instances (defaults; LAT2/READ_FIRST/DEPTH 20;
//   NO_CHANGE/no clear/DEPTH 16 with a 4-bit address) are driven by directed
//   sequences and then random traffic. A word-level reference model predicts
//   every output of every instance each cycle.
// -----------------------------------------------------------------------------
module tb_sp_ram_be;

   logic        clk;
   logic        rst   [3];
   logic        cs    [3];
   logic        we    [3];
   logic [3:0]  be    [3];
   logic [10:0] addr  [3];
   logic [31:0] din   [3];
   logic [31:0] dout  [3];
   logic        rvalid[3];
   logic        busy  [3];
   logic        aerr  [3];

   int n_chk  = 0;
   int n_pass = 0;

   // reference model state
   logic [31:0] mm [3][2048];
   logic [3:0]  mk [3][2048];   // known-byte flags for the uncleared instance
   int          busy_left [3];
   logic        e_rv  [3];
   logic [31:0] e_do  [3];
   logic [31:0] e_dm  [3];
   logic        e_err [3];
   logic        p_v   [3];
   logic [31:0] p_d   [3];
   logic [31:0] p_m   [3];

   sp_ram_be u_dut0 (
      .I_CLK(clk), .I_RST(rst[0]), .i_cs(cs[0]), .i_we(we[0]), .i_be(be[0]),
      .i_addr(addr[0]), .i_din(din[0]), .o_dout(dout[0]), .o_rvalid(rvalid[0]),
      .o_busy(busy[0]), .o_addr_err(aerr[0])
   );

   sp_ram_be #(
      .ADDR_WIDTH(11), .DATA_WIDTH(32), .DEPTH(20), .RD_LATENCY(2),
      .RDW_MODE(1), .CLEAR_ON_RESET(1)
   ) u_dut1 (
      .I_CLK(clk), .I_RST(rst[1]), .i_cs(cs[1]), .i_we(we[1]), .i_be(be[1]),
      .i_addr(addr[1]), .i_din(din[1]), .o_dout(dout[1]), .o_rvalid(rvalid[1]),
      .o_busy(busy[1]), .o_addr_err(aerr[1])
   );

   sp_ram_be #(
      .ADDR_WIDTH(4), .DATA_WIDTH(32), .DEPTH(16), .RD_LATENCY(1),
      .RDW_MODE(2), .CLEAR_ON_RESET(0)
   ) u_dut2 (
      .I_CLK(clk), .I_RST(rst[2]), .i_cs(cs[2]), .i_we(we[2]), .i_be(be[2]),
      .i_addr(addr[2][3:0]), .i_din(din[2]), .o_dout(dout[2]), .o_rvalid(rvalid[2]),
      .o_busy(busy[2]), .o_addr_err(aerr[2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int dep(int d);
      return (d == 0) ? 1920 : (d == 1) ? 20 : 16;
   endfunction
   function automatic int lat(int d);
      return (d == 1) ? 2 : 1;
   endfunction
   function automatic int rdw(int d);
      return d;
   endfunction
   function automatic bit clr(int d);
      return d != 2;
   endfunction
   function automatic int unsigned amask(int d);
      return (d == 2) ? 15 : 2047;
   endfunction
   function automatic logic [31:0] bexp(logic [3:0] m);
      logic [31:0] r;
      for (int k = 0; k < 4; k++) r[8*k +: 8] = {8{m[k]}};
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // One rising edge of the reference model, using the inputs as driven.
   task automatic model_edge();
      int unsigned ad;
      logic        inr, acc_ok, r_v;
      logic [31:0] old, om, nw, nm, r_d, r_m;
      for (int d = 0; d < 3; d++) begin
         if (rst[d]) begin
            busy_left[d] = clr(d) ? dep(d) : 0;
            e_rv[d] = 1'b0; e_do[d] = '0; e_dm[d] = '1; e_err[d] = 1'b0;
            p_v[d] = 1'b0;
         end else begin
            acc_ok = cs[d] && (busy_left[d] == 0);
            if (busy_left[d] > 0) begin
               busy_left[d]--;
               if (busy_left[d] == 0) begin
                  for (int i = 0; i < dep(d); i++) begin
                     mm[d][i] = '0;
                     mk[d][i] = 4'hF;
                  end
               end
            end
            ad  = 32'(addr[d]) & amask(d);
            inr = ad < 32'(dep(d));
            r_v = 1'b0; r_d = '0; r_m = '1;
            if (acc_ok) begin
               old = inr ? mm[d][ad] : '0;
               om  = inr ? bexp(mk[d][ad]) : '1;
               if (we[d]) begin
                  nw = old; nm = om;
                  for (int k = 0; k < 4; k++) begin
                     if (be[d][k]) begin
                        nw[8*k +: 8] = din[d][8*k +: 8];
                        nm[8*k +: 8] = 8'hFF;
                     end
                  end
                  if (inr) begin
                     mm[d][ad] = nw;
                     mk[d][ad] = mk[d][ad] | be[d];
                  end else begin
                     nw = '0; nm = '1;
                  end
                  r_v = (rdw(d) != 2);
                  r_d = (rdw(d) == 0) ? nw : old;
                  r_m = (rdw(d) == 0) ? nm : om;
               end else begin
                  r_v = 1'b1; r_d = old; r_m = om;
               end
            end
            e_err[d] = acc_ok && !inr;
            if (lat(d) == 1) begin
               e_rv[d] = r_v;
               if (r_v) begin e_do[d] = r_d; e_dm[d] = r_m; end
            end else begin
               e_rv[d] = p_v[d];
               if (p_v[d]) begin e_do[d] = p_d[d]; e_dm[d] = p_m[d]; end
               p_v[d] = r_v; p_d[d] = r_d; p_m[d] = r_m;
            end
         end
      end
   endtask

   // Advance one cycle and compare every output of every instance.
   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         check($sformatf("busy[%0d]", d), 32'(busy[d]), 32'(busy_left[d] > 0));
         check($sformatf("rvalid[%0d]", d), 32'(rvalid[d]), 32'(e_rv[d]));
         check($sformatf("addr_err[%0d]", d), 32'(aerr[d]), 32'(e_err[d]));
         check($sformatf("dout[%0d]", d), dout[d] & e_dm[d], e_do[d] & e_dm[d]);
      end
   endtask

   task automatic acc(input int d, input logic w, input logic [3:0] b,
                      input logic [10:0] a, input logic [31:0] v);
      cs[d] = 1'b1; we[d] = w; be[d] = b; addr[d] = a; din[d] = v;
      step();
      cs[d] = 1'b0;
   endtask

   function automatic logic [10:0] rand_addr(int d);
      int unsigned r;
      r = $urandom % 10;
      if (r < 6)      return 11'($urandom_range(0, 15));
      else if (r < 8) return 11'($urandom_range(dep(d) - 4, dep(d) - 1));
      else if (r < 9) return 11'($urandom_range(dep(d), 2047));
      else            return 11'($urandom_range(0, 2047));
   endfunction

   initial begin
      for (int d = 0; d < 3; d++) begin
         rst[d] = 1'b1; cs[d] = 1'b0; we[d] = 1'b0; be[d] = '0;
         addr[d] = '0; din[d] = '0;
         busy_left[d] = 0; p_v[d] = 1'b0;
         e_rv[d] = 1'b0; e_do[d] = '0; e_dm[d] = '1; e_err[d] = 1'b0;
         for (int i = 0; i < 2048; i++) begin
            mm[d][i] = '0; mk[d][i] = 4'h0;
         end
      end
      @(negedge clk);
      step();
      step();

      // Release; d0 requests a read throughout its clear, d2 writes at once.
      for (int d = 0; d < 3; d++) rst[d] = 1'b0;
      cs[0] = 1'b1; we[0] = 1'b0; addr[0] = 11'd1919;
      cs[2] = 1'b1; we[2] = 1'b1; be[2] = 4'hF; addr[2] = 11'd7; din[2] = 32'h12345678;
      step();
      cs[2] = 1'b0;
      repeat (1919) step();
      check("clear_len_busy", 32'(busy[0]), 32'd0);
      step();
      check("rd1919_valid", 32'(rvalid[0]), 32'd1);
      check("rd1919_data", dout[0], 32'h0);
      cs[0] = 1'b0;

      // Byte-lane merge.
      acc(0, 1'b1, 4'hF, 11'd5, 32'hAABBCCDD);
      acc(0, 1'b1, 4'h5, 11'd5, 32'h11223344);
      acc(0, 1'b0, 4'h0, 11'd5, 32'h0);
      check("be_merge", dout[0], 32'hAA22CC44);

      // Read-during-write in each mode.
      acc(0, 1'b1, 4'hF, 11'd7, 32'h12345678);
      acc(0, 1'b1, 4'hF, 11'd7, 32'hCAFEF00D);
      check("rdw0_valid", 32'(rvalid[0]), 32'd1);
      check("rdw0_data", dout[0], 32'hCAFEF00D);
      acc(1, 1'b1, 4'hF, 11'd7, 32'h12345678);
      acc(1, 1'b1, 4'hF, 11'd7, 32'hCAFEF00D);
      step();
      check("rdw1_valid", 32'(rvalid[1]), 32'd1);
      check("rdw1_data", dout[1], 32'h12345678);
      acc(2, 1'b1, 4'hF, 11'd7, 32'hCAFEF00D);
      check("rdw2_valid", 32'(rvalid[2]), 32'd0);
      check("rdw2_hold", dout[2], 32'h0);
      acc(2, 1'b0, 4'h0, 11'd7, 32'h0);
      check("rdw2_readback", dout[2], 32'hCAFEF00D);

      // Out-of-range accesses.
      acc(0, 1'b1, 4'hF, 11'd1920, 32'hDEADBEEF);
      check("oor_wr_err", 32'(aerr[0]), 32'd1);
      check("oor_wr_data", dout[0], 32'h0);
      acc(0, 1'b0, 4'h0, 11'd2047, 32'h0);
      check("oor_rd_err", 32'(aerr[0]), 32'd1);
      check("oor_rd_valid", 32'(rvalid[0]), 32'd1);
      acc(0, 1'b0, 4'h0, 11'd1919, 32'h0);
      check("oor_mem1919", dout[0], 32'h0);
      check("oor_no_err", 32'(aerr[0]), 32'd0);
      acc(0, 1'b0, 4'h0, 11'd0, 32'h0);
      check("oor_mem0", dout[0], 32'h0);

      // Latency-2 back-to-back reads.
      acc(1, 1'b1, 4'hF, 11'd1, 32'h01010101);
      acc(1, 1'b1, 4'hF, 11'd2, 32'h02020202);
      acc(1, 1'b1, 4'hF, 11'd3, 32'h03030303);
      step();
      step();
      cs[1] = 1'b1; we[1] = 1'b0; addr[1] = 11'd1;
      step();
      check("lat2_e1_valid", 32'(rvalid[1]), 32'd0);
      addr[1] = 11'd2;
      step();
      check("lat2_r1_valid", 32'(rvalid[1]), 32'd1);
      check("lat2_r1_data", dout[1], 32'h01010101);
      addr[1] = 11'd3;
      step();
      check("lat2_r2_data", dout[1], 32'h02020202);
      cs[1] = 1'b0;
      step();
      check("lat2_r3_valid", 32'(rvalid[1]), 32'd1);
      check("lat2_r3_data", dout[1], 32'h03030303);
      step();
      check("lat2_end_valid", 32'(rvalid[1]), 32'd0);

      // Reset with a latency-2 read in flight.
      acc(1, 1'b0, 4'h0, 11'd2, 32'h0);
      rst[1] = 1'b1;
      #1;
      check("flush_dout", dout[1], 32'h0);
      step();
      rst[1] = 1'b0;
      repeat (22) step();

      // Reset keeps array contents.
      rst[2] = 1'b1;
      step();
      rst[2] = 1'b0;
      acc(2, 1'b0, 4'h0, 11'd7, 32'h0);
      check("rst_keeps_mem", dout[2], 32'hCAFEF00D);

      // Reset during clear restarts it.
      acc(0, 1'b0, 4'h0, 11'd5, 32'h0);
      check("pre_rst_data", dout[0], 32'hAA22CC44);
      rst[0] = 1'b1;
      #1;
      check("rst_async_dout", dout[0], 32'h0);
      check("rst_async_busy", 32'(busy[0]), 32'd1);
      step();
      rst[0] = 1'b0;
      repeat (1000) step();
      rst[0] = 1'b1;
      step();
      check("rst_mid_dout", dout[0], 32'h0);
      rst[0] = 1'b0;
      repeat (1919) step();
      check("restart_busy_last", 32'(busy[0]), 32'd1);
      step();
      check("restart_done", 32'(busy[0]), 32'd0);

      // Random traffic on all three instances at once.
      repeat (600) begin
         for (int d = 0; d < 3; d++) begin
            cs[d]   = ($urandom % 10) < 7;
            we[d]   = 1'($urandom % 2);
            be[d]   = 4'($urandom);
            addr[d] = rand_addr(d);
            din[d]  = $urandom;
         end
         step();
      end
      for (int d = 0; d < 3; d++) cs[d] = 1'b0;
      repeat (3) step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/sp_ram_be.md
SP_RAM_BE -- requirements
Module: sp_ram_be

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 11, word address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, word width; legal values are multiples of 8.
REQ-003 The block SHALL have parameter DEPTH, default 1920, number of words; legal range 2 to 2^ADDR_WIDTH.
REQ-004 The block SHALL have parameter RD_LATENCY, default 1, cycles from accepted access to o_rvalid; legal values 1 or 2.
REQ-005 The block SHALL have parameter RDW_MODE, default 0, write-access read port behaviour: 0=WRITE_FIRST, 1=READ_FIRST, 2=NO_CHANGE.
REQ-006 The block SHALL have parameter CLEAR_ON_RESET, default 1, where 1 zeroes the whole array after reset.
REQ-007 The block SHALL have the following ports:
  I_CLK  in  1  clock; all logic on the rising edge.
  I_RST  in  1  asynchronous, active-high reset.
  i_cs  in  1  access request.
  i_we  in  1  1=write, 0=read.
  i_be  in  DATA_WIDTH/8  byte write enables, bit k covers din[8k+7:8k].
  i_addr  in  ADDR_WIDTH  word address.
  i_din  in  DATA_WIDTH  write data.
  o_dout  out  DATA_WIDTH  read data, held between reads.
  o_rvalid  out  1  one-cycle strobe, o_dout updated.
  o_busy  out  1  clear in progress, accesses ignored.
  o_addr_err  out  1  one-cycle strobe, out-of-range access.

Function
REQ-008 An access SHALL be accepted on a rising edge with i_cs=1 and o_busy=0; i_cs while o_busy=1 SHALL be dropped with no response.
REQ-009 An accepted write to i_addr < DEPTH SHALL update only the byte lanes with i_be[k]=1; other lanes SHALL keep their values.
REQ-010 An accepted read to i_addr < DEPTH SHALL drive mem[i_addr] on o_dout with o_rvalid=1 exactly RD_LATENCY cycles after acceptance.
REQ-011 With RD_LATENCY=2 an accepted access SHALL be taken every cycle, with one result per cycle in order.
REQ-012 For an accepted write, RDW_MODE=0 SHALL return the merged new word with o_rvalid, RDW_MODE=1 SHALL return the old word with o_rvalid, and RDW_MODE=2 SHALL leave o_dout unchanged with no o_rvalid.
REQ-013 A write with i_be all zero SHALL leave memory unchanged and SHALL follow REQ-012, returning the unchanged word.
REQ-014 An access with i_addr >= DEPTH SHALL NOT modify memory.
REQ-015 An access with i_addr >= DEPTH SHALL pulse o_addr_err one cycle after acceptance.
REQ-016 An out-of-range read, or an out-of-range write under RDW_MODE 0 or 1, SHALL return o_dout=0 with o_rvalid at normal latency.
REQ-017 o_dout SHALL hold its last value when no o_rvalid is issued.
REQ-018 The state machine SHALL have two states, CLEAR and READY; o_busy SHALL be 1 exactly in CLEAR.
REQ-019 In CLEAR, a counter SHALL write 0 to addresses 0..DEPTH-1, one per cycle; after writing DEPTH-1 the next state SHALL be READY, giving DEPTH busy cycles.
REQ-020 With CLEAR_ON_RESET=0, reset SHALL go straight to READY and the array SHALL be left uninitialised.
REQ-021 Read-pipeline results still in flight when CLEAR begins SHALL be discarded.

Reset
REQ-022 While I_RST=1 the block SHALL hold o_dout=0, o_rvalid=0 and o_addr_err=0.
REQ-023 While I_RST=1, o_busy SHALL equal CLEAR_ON_RESET and the clear counter SHALL be 0.
REQ-024 I_RST SHALL NOT reset the array; contents SHALL change only through writes or CLEAR.
REQ-025 Asserting I_RST during CLEAR SHALL restart the clear from address 0 after deassertion.
REQ-026 After I_RST deasserts, the first rising edge SHALL perform clear address 0, or accept an access when CLEAR_ON_RESET=0.

Verification
REQ-027 Defaults: release I_RST, drive i_cs=1 throughout -> o_busy=1 for 1920 cycles, no o_rvalid; then a read of addr 1919 returns 0x00000000 one cycle later.
REQ-028 Byte-enable test: write 0xAABBCCDD to addr 5 with be=1111, then 0x11223344 with be=0101, then read addr 5 -> o_dout=0xAA22CC44.
REQ-029 RDW test with mem[7]=0x12345678, write 0xCAFEF00D to addr 7 with be=1111: mode 0 -> o_rvalid with 0xCAFEF00D; mode 1 -> 0x12345678; mode 2 -> no o_rvalid, o_dout unchanged.
REQ-030 Range test: write addr 1920 then read addr 2047 -> o_addr_err pulses on both accesses, read returns 0, mem[0] and mem[1919] unchanged.
REQ-031 Latency test with RD_LATENCY=2: back-to-back reads of addrs 1,2,3 -> o_rvalid high 3 consecutive cycles starting 2 cycles after the first read, data in order.
REQ-032 Reset test: assert I_RST for 1 cycle at clear count 1000 -> o_busy stays 1 for a further 1920 cycles after release, and o_dout=0 while I_RST=1.
